// File: rtl/csr_axi_pkg.sv
// Shared AXI encodings and FSM state types for the CSR register-array slave.
package csr_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/csr_burst_addr.sv
// Next word address for an AXI burst beat: FIXED holds, INCR wraps at the array depth.
module csr_burst_addr
    import csr_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr_c
);

    // Modulo-depth wrap falls out of the natural ADDR_W-bit overflow.
    always_comb begin
        next_addr_c = addr;
        if (burst == BURST_INCR) begin
            next_addr_c = addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/csr_axi_regs.sv
// AXI4 slave over a word-addressed CSR array with independent write and read FSMs.
module csr_axi_regs
    import csr_axi_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 5,
    parameter int unsigned             ID_W      = 5,
    parameter logic [31:0]             RESET_VAL = 32'h0,
    parameter logic [(2**ADDR_W)-1:0]  RO_MASK   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    // Write channel state
    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q,  w_addr_d;
    logic [ID_W-1:0]   w_id_q,    w_id_d;
    logic [7:0]        w_len_q,   w_len_d;
    logic [7:0]        w_beat_q,  w_beat_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic              w_bad_q,   w_bad_d;
    logic              w_lerr_q,  w_lerr_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [ID_W-1:0]   bid_q,     bid_d;
    logic              run_q,     run_d;

    // Read channel state
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q,  r_addr_d;
    logic [7:0]        r_len_q,   r_len_d;
    logic [7:0]        r_beat_q,  r_beat_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic              r_bad_q,   r_bad_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [ID_W-1:0]   rid_q,     rid_d;

    logic              aw_hs_c;
    logic              aw_bad_c;
    logic              aw_lerr_c;
    logic              ar_bad_c;
    logic              w_last_beat_c;
    logic              we_c;
    logic [ADDR_W-1:0] we_addr_c;
    logic [ADDR_W-1:0] w_cur_addr_c, w_next_addr_c, r_cur_addr_c, r_next_addr_c;
    logic [1:0]        w_cur_burst_c, r_cur_burst_c;
    logic [31:0]       rd_word_c;

    // In idle the generators see the incoming request, otherwise the latched burst.
    assign w_cur_addr_c  = (w_state_q == W_IDLE) ? s_axi_awaddr  : w_addr_q;
    assign w_cur_burst_c = (w_state_q == W_IDLE) ? s_axi_awburst : w_burst_q;
    assign r_cur_addr_c  = (r_state_q == R_IDLE) ? s_axi_araddr  : r_addr_q;
    assign r_cur_burst_c = (r_state_q == R_IDLE) ? s_axi_arburst : r_burst_q;
    assign rd_word_c     = mem_q[r_cur_addr_c];

    csr_burst_addr #(.ADDR_W(ADDR_W)) u_w_addr (
        .addr        (w_cur_addr_c),
        .burst       (w_cur_burst_c),
        .next_addr_c (w_next_addr_c)
    );

    csr_burst_addr #(.ADDR_W(ADDR_W)) u_r_addr (
        .addr        (r_cur_addr_c),
        .burst       (r_cur_burst_c),
        .next_addr_c (r_next_addr_c)
    );

    // AW and the first W beat are only taken together, and never before the first post-reset edge.
    assign aw_hs_c       = (w_state_q == W_IDLE) && run_q && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = aw_hs_c;
    assign s_axi_wready  = aw_hs_c || (w_state_q == W_DATA);
    assign aw_bad_c      = (s_axi_awsize != SIZE_WORD) || (s_axi_awburst == BURST_RSVD);
    assign aw_lerr_c     = s_axi_wlast != (s_axi_awlen == 8'd0);
    assign ar_bad_c      = (s_axi_arsize != SIZE_WORD) || (s_axi_arburst == BURST_RSVD);
    assign w_last_beat_c = (w_beat_q == w_len_q);

    // Write FSM next state
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_burst_d = w_burst_q;
        w_bad_d   = w_bad_q;
        w_lerr_d  = w_lerr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        we_c      = 1'b0;
        we_addr_c = w_addr_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    w_id_d    = s_axi_awid;
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_bad_d   = aw_bad_c;
                    w_lerr_d  = aw_lerr_c;
                    w_addr_d  = w_next_addr_c;
                    w_beat_d  = 8'd1;
                    we_c      = !aw_bad_c;
                    we_addr_c = s_axi_awaddr;
                    if (s_axi_awlen == 8'd0) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bid_d     = s_axi_awid;
                        bresp_d   = (aw_bad_c || aw_lerr_c) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_state_d = W_DATA;
                    end
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    we_c      = !w_bad_q;
                    we_addr_c = w_addr_q;
                    w_lerr_d  = w_lerr_q || (s_axi_wlast != w_last_beat_c);
                    if (w_last_beat_c) begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_bad_q || w_lerr_d) ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        w_addr_d = w_next_addr_c;
                        w_beat_d = 8'(w_beat_q + 8'd1);
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Byte-strobed array update; read-only words never change.
    always_comb begin
        mem_d = mem_q;
        if (we_c && !RO_MASK[we_addr_c]) begin
            for (int k = 0; k < 4; k++) begin
                if (s_axi_wstrb[k]) begin
                    mem_d[we_addr_c][8*k +: 8] = s_axi_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read FSM next state; rdata always comes from the pre-edge array contents.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_burst_d = r_burst_q;
        r_bad_d   = r_bad_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        run_d     = 1'b1;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    r_bad_d   = ar_bad_c;
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_addr_d  = r_next_addr_c;
                    r_beat_d  = 8'd0;
                    rvalid_d  = 1'b1;
                    rid_d     = s_axi_arid;
                    rdata_d   = ar_bad_c ? 32'h0 : rd_word_c;
                    rresp_d   = ar_bad_c ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (r_beat_q == r_len_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = 8'(r_beat_q + 8'd1);
                        r_addr_d = r_next_addr_c;
                        rdata_d  = r_bad_q ? 32'h0 : rd_word_c;
                        rlast_d  = (r_beat_d == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_lerr_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
            run_q     <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
        end else begin
            mem_q     <= mem_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_burst_q <= w_burst_d;
            w_bad_q   <= w_bad_d;
            w_lerr_q  <= w_lerr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            run_q     <= run_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_burst_q <= r_burst_d;
            r_bad_q   <= r_bad_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;

endmodule
